// File: rtl/mips_core_pkg.sv
// ---------------------------------------------------------------------------
// mips_core_pkg
// Shared core types. MipsLogic names the 64 physical register tags p0..p63.
// The free list adds the register-count localparams and the FreeListPtr
// pointer type (bit 5 = wrap, bits 4:0 = index).
// ---------------------------------------------------------------------------
package mips_core_pkg;

    typedef enum logic [5:0] {
        p0,  p1,  p2,  p3,  p4,  p5,  p6,  p7,
        p8,  p9,  p10, p11, p12, p13, p14, p15,
        p16, p17, p18, p19, p20, p21, p22, p23,
        p24, p25, p26, p27, p28, p29, p30, p31,
        p32, p33, p34, p35, p36, p37, p38, p39,
        p40, p41, p42, p43, p44, p45, p46, p47,
        p48, p49, p50, p51, p52, p53, p54, p55,
        p56, p57, p58, p59, p60, p61, p62, p63
    } MipsLogic;

    localparam int PHYS_REG_COUNT = 64;
    localparam int ARCH_REG_COUNT = 32;

    typedef logic [5:0] FreeListPtr;

endpackage

// File: rtl/phys_reg_free_list_if.sv
// ---------------------------------------------------------------------------
// phys_reg_free_list_if
// Bundles the rename/commit side of the physical register free list.
//   master : rename + commit (drives alloc_req, release_*, ckpt_*)
//   slave  : the free list    (drives alloc_valid, alloc_preg, free_count,
//                              overflow)
// ---------------------------------------------------------------------------
import mips_core_pkg::*;

interface phys_reg_free_list_if;
    logic       alloc_req;
    logic       alloc_valid;
    MipsLogic   alloc_preg;
    logic       release_valid;
    MipsLogic   release_preg;
    logic       ckpt_save;
    logic       ckpt_restore;
    logic [5:0] free_count;
    logic       overflow;

    modport master (
        output alloc_req, release_valid, release_preg, ckpt_save, ckpt_restore,
        input  alloc_valid, alloc_preg, free_count, overflow
    );

    modport slave (
        input  alloc_req, release_valid, release_preg, ckpt_save, ckpt_restore,
        output alloc_valid, alloc_preg, free_count, overflow
    );
endinterface

// File: rtl/free_list_ram.sv
// ---------------------------------------------------------------------------
// free_list_ram
// DEPTH x MipsLogic storage for the free list. One asynchronous read port
// (head), one synchronous write port (tail). Reset loads entry[i] = p(BASE+i).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_en/wr_idx/wr_data  synchronous write
//   rd_idx/rd_data        combinational read
// ---------------------------------------------------------------------------
import mips_core_pkg::*;

module free_list_ram #(
    parameter int DEPTH = 32,
    parameter int BASE  = 32,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  MipsLogic         wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output MipsLogic         rd_data
);

    MipsLogic entries [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= MipsLogic'(6'(BASE + i));
            end
        end else if (wr_en) begin
            entries[wr_idx] <= wr_data;
        end
    end

    assign rd_data = entries[rd_idx];

endmodule

// File: rtl/phys_reg_free_list.sv
// ---------------------------------------------------------------------------
// phys_reg_free_list
// Circular FIFO of free physical register tags for the rename stage.
// Rename pops the head tag (valid combinationally in the request cycle);
// commit pushes retired tags at the tail. Allocation order is strict FIFO.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   fl (slave)   alloc_req/alloc_valid/alloc_preg, release_valid/release_preg,
//                ckpt_save/ckpt_restore, free_count, overflow
// Configuration:
//   FREE_LIST_CHECKPOINT_EN  builds the head snapshot register and the
//                            restore path; otherwise ckpt_* are ignored.
// ---------------------------------------------------------------------------
import mips_core_pkg::*;

module phys_reg_free_list #(
    parameter int PHYS_REGS = PHYS_REG_COUNT,
    parameter int ARCH_REGS = ARCH_REG_COUNT,
    parameter int DEPTH     = PHYS_REGS - ARCH_REGS,
    localparam int IDX_W    = $clog2(DEPTH)
) (
    input logic                 clk,
    input logic                 rst_n,
    phys_reg_free_list_if.slave fl
);

    if (PHYS_REGS != 2 ** $bits(MipsLogic) || DEPTH != 2 ** IDX_W ||
        IDX_W + 1 != $bits(FreeListPtr)) begin : g_bad_cfg
        $error("phys_reg_free_list: inconsistent PHYS_REGS/ARCH_REGS/DEPTH");
    end

    FreeListPtr head_q;
    FreeListPtr tail_q;
    FreeListPtr head_post_pop;
    FreeListPtr head_d;
    FreeListPtr count;
    logic       overflow_q;
    logic       empty;
    logic       full;
    logic       restore;
    logic       pop;
    logic       push;
    logic       release_bad;

    // Empty/full come from registered pointers only, so a tag pushed this
    // cycle can never be popped in the same cycle (no bypass).
    assign count = tail_q - head_q;
    assign empty = (head_q == tail_q);
    assign full  = (count == FreeListPtr'(DEPTH));

`ifdef FREE_LIST_CHECKPOINT_EN
    FreeListPtr snap_q;
    assign restore = fl.ckpt_restore;
`else
    logic unused_ckpt;
    assign unused_ckpt = fl.ckpt_save ^ fl.ckpt_restore;
    assign restore     = 1'b0;
`endif

    assign pop         = fl.alloc_req && !empty && !restore;
    assign push        = fl.release_valid && (fl.release_preg != p0) && !full;
    assign release_bad = fl.release_valid && ((fl.release_preg == p0) || full);

    assign head_post_pop = head_q + FreeListPtr'(pop);

`ifdef FREE_LIST_CHECKPOINT_EN
    assign head_d = restore ? snap_q : head_post_pop;
`else
    assign head_d = head_post_pop;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= FreeListPtr'(DEPTH);
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_q + FreeListPtr'(push);
            overflow_q <= overflow_q | release_bad;
        end
    end

`ifdef FREE_LIST_CHECKPOINT_EN
    // Snapshot captures the post-pop head; a simultaneous restore wins and
    // leaves the snapshot untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_q <= '0;
        end else if (fl.ckpt_save && !fl.ckpt_restore) begin
            snap_q <= head_post_pop;
        end
    end
`endif

    free_list_ram #(
        .DEPTH (DEPTH),
        .BASE  (ARCH_REGS)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_idx  (tail_q[IDX_W-1:0]),
        .wr_data (fl.release_preg),
        .rd_idx  (head_q[IDX_W-1:0]),
        .rd_data (fl.alloc_preg)
    );

    assign fl.alloc_valid = !empty;
    assign fl.free_count  = count;
    assign fl.overflow    = overflow_q;

endmodule

// File: tb/tb_phys_reg_free_list.sv
// ---------------------------------------------------------------------------
// tb_phys_reg_free_list
// Directed testbench for phys_reg_free_list. Honors FREE_LIST_CHECKPOINT_EN
// to choose the expected behaviour of the checkpoint sequence.
// ---------------------------------------------------------------------------
import mips_core_pkg::*;

module tb_phys_reg_free_list;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    phys_reg_free_list_if fl_if ();

    phys_reg_free_list dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fl    (fl_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic alloc, input logic rel_v,
                                 input MipsLogic rel_p, input logic save,
                                 input logic restore);
        fl_if.alloc_req     = alloc;
        fl_if.release_valid = rel_v;
        fl_if.release_preg  = rel_p;
        fl_if.ckpt_save     = save;
        fl_if.ckpt_restore  = restore;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] obs,
                               input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        applyStimulus(1'b0, 1'b0, p0, 1'b0, 1'b0);
        #12;

        // Reset state
        checkOutput("rst_count", fl_if.free_count, 8'd32);
        checkOutput("rst_valid", fl_if.alloc_valid, 8'd1);
        checkOutput("rst_preg", fl_if.alloc_preg, 8'd32);
        checkOutput("rst_ovf", fl_if.overflow, 8'd0);
        rst_n = 1'b1;
        tick();

        // Drain all 32 tags in FIFO order
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b1, 1'b0, p0, 1'b0, 1'b0);
            checkOutput("drain_preg", fl_if.alloc_preg, 8'(32 + i));
            checkOutput("drain_valid", fl_if.alloc_valid, 8'd1);
            tick();
        end
        applyStimulus(1'b1, 1'b0, p0, 1'b0, 1'b0);
        checkOutput("empty_valid", fl_if.alloc_valid, 8'd0);
        checkOutput("empty_count", fl_if.free_count, 8'd0);
        tick();
        checkOutput("empty_stays", fl_if.free_count, 8'd0);

        // Release into an empty list: no bypass in the push cycle
        applyStimulus(1'b1, 1'b1, p40, 1'b0, 1'b0);
        checkOutput("nobypass_valid", fl_if.alloc_valid, 8'd0);
        tick();
        applyStimulus(1'b0, 1'b0, p0, 1'b0, 1'b0);
        checkOutput("rel40_valid", fl_if.alloc_valid, 8'd1);
        checkOutput("rel40_preg", fl_if.alloc_preg, 8'd40);
        checkOutput("rel40_count", fl_if.free_count, 8'd1);

        // Pop p40 while pushing p45, then pop p45 while pushing p50
        applyStimulus(1'b1, 1'b1, p45, 1'b0, 1'b0);
        checkOutput("pp1_preg", fl_if.alloc_preg, 8'd40);
        tick();
        applyStimulus(1'b1, 1'b1, p50, 1'b0, 1'b0);
        checkOutput("pp2_preg", fl_if.alloc_preg, 8'd45);
        checkOutput("pp2_count", fl_if.free_count, 8'd1);
        tick();
        applyStimulus(1'b0, 1'b0, p0, 1'b0, 1'b0);
        checkOutput("pp3_preg", fl_if.alloc_preg, 8'd50);
        checkOutput("pp3_count", fl_if.free_count, 8'd1);

        // Fill to 32, then release while full
        for (int i = 1; i <= 31; i++) begin
            applyStimulus(1'b0, 1'b1, MipsLogic'(6'(i)), 1'b0, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, p0, 1'b0, 1'b0);
        checkOutput("full_count", fl_if.free_count, 8'd32);
        checkOutput("full_ovf0", fl_if.overflow, 8'd0);
        applyStimulus(1'b0, 1'b1, p33, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, p0, 1'b0, 1'b0);
        checkOutput("full_ovf1", fl_if.overflow, 8'd1);
        checkOutput("full_count2", fl_if.free_count, 8'd32);
        checkOutput("full_head", fl_if.alloc_preg, 8'd50);
        tick();
        checkOutput("ovf_sticky", fl_if.overflow, 8'd1);

        // Reset, pop one, then release p0
        rst_n = 1'b0;
        #1;
        checkOutput("rst2_ovf", fl_if.overflow, 8'd0);
        rst_n = 1'b1;
        tick();
        applyStimulus(1'b1, 1'b0, p0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1, p0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, p0, 1'b0, 1'b0);
        checkOutput("p0_ovf", fl_if.overflow, 8'd1);
        checkOutput("p0_count", fl_if.free_count, 8'd31);
        checkOutput("p0_head", fl_if.alloc_preg, 8'd33);

        // Pop to count 7, then asynchronous reset mid-cycle
        for (int i = 0; i < 24; i++) begin
            applyStimulus(1'b1, 1'b0, p0, 1'b0, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, p0, 1'b0, 1'b0);
        checkOutput("mid_count", fl_if.free_count, 8'd7);
        checkOutput("mid_preg", fl_if.alloc_preg, 8'd57);
        applyStimulus(1'b1, 1'b1, p20, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_count", fl_if.free_count, 8'd32);
        checkOutput("arst_preg", fl_if.alloc_preg, 8'd32);
        checkOutput("arst_ovf", fl_if.overflow, 8'd0);
        applyStimulus(1'b0, 1'b0, p0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();

        // Checkpoint save/restore
        applyStimulus(1'b1, 1'b0, p0, 1'b1, 1'b0);
        checkOutput("ck_p32", fl_if.alloc_preg, 8'd32);
        tick();
        applyStimulus(1'b1, 1'b0, p0, 1'b0, 1'b0);
        checkOutput("ck_p33", fl_if.alloc_preg, 8'd33);
        tick();
        applyStimulus(1'b1, 1'b0, p0, 1'b0, 1'b0);
        checkOutput("ck_p34", fl_if.alloc_preg, 8'd34);
        tick();
        applyStimulus(1'b1, 1'b0, p0, 1'b0, 1'b1);
        checkOutput("ck_rst_cyc", fl_if.alloc_preg, 8'd35);
        tick();
        applyStimulus(1'b0, 1'b0, p0, 1'b0, 1'b0);
`ifdef FREE_LIST_CHECKPOINT_EN
        checkOutput("ck_after_preg", fl_if.alloc_preg, 8'd33);
        checkOutput("ck_after_count", fl_if.free_count, 8'd31);
`else
        checkOutput("ck_after_preg", fl_if.alloc_preg, 8'd36);
        checkOutput("ck_after_count", fl_if.free_count, 8'd28);
`endif
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
